// File: rtl/regs_scoreboard.sv
// Register hazard scoreboard with a round-robin arbiter for the shared
// register-file write port (wb0 = ALU, wb1 = LSU).
module regs_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [REG_AW-1:0]  issue_rs1,
    input  logic [REG_AW-1:0]  issue_rs2,
    input  logic               issue_rs1_en,
    input  logic               issue_rs2_en,
    input  logic [REG_AW-1:0]  issue_rd,
    input  logic               issue_rd_en,
    output logic               issue_ready,
    input  logic               wb0_valid,
    input  logic [REG_AW-1:0]  wb0_addr,
    input  logic [XLEN-1:0]    wb0_data,
    output logic               wb0_ready,
    input  logic               wb1_valid,
    input  logic [REG_AW-1:0]  wb1_addr,
    input  logic [XLEN-1:0]    wb1_data,
    output logic               wb1_ready,
    output logic               regs_write_en,
    output logic [REG_AW-1:0]  regs_write_addr,
    output logic [XLEN-1:0]    regs_write_data,
    output logic [REG_NUM-1:0] busy,
    output logic               wb_err
);

    logic [REG_NUM-1:0] busy_q, busy_d;
    logic               last_grant_q, last_grant_d;
    logic               we_q, we_d;
    logic [REG_AW-1:0]  waddr_q, waddr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic               wb_err_q, wb_err_d;

    logic               hz_rs1, hz_rs2, hz_rd;
    logic               issue_fire;
    logic               gnt0, gnt1, gnt_any;
    logic [REG_AW-1:0]  gnt_addr;
    logic [XLEN-1:0]    gnt_data;

    always_comb begin
        hz_rs1      = issue_rs1_en & busy_q[issue_rs1];
        hz_rs2      = issue_rs2_en & busy_q[issue_rs2];
        hz_rd       = issue_rd_en  & busy_q[issue_rd];
        issue_ready = ~(hz_rs1 | hz_rs2 | hz_rd);
        issue_fire  = issue_valid & issue_ready & issue_rd_en
                    & (issue_rd != '0);
    end

    // On contention the requester that did not win last time is granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (1'b1)
            (wb0_valid & ~wb1_valid): gnt0 = 1'b1;
            (~wb0_valid & wb1_valid): gnt1 = 1'b1;
            (wb0_valid & wb1_valid): begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end
            default: ;
        endcase
        gnt_any  = gnt0 | gnt1;
        gnt_addr = gnt1 ? wb1_addr : wb0_addr;
        gnt_data = gnt1 ? wb1_data : wb0_data;
    end

    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = gnt_any;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wb_err_d     = wb_err_q;
        if (gnt_any) begin
            last_grant_d = gnt1;
            waddr_d      = gnt_addr;
            wdata_d      = gnt_data;
            // x0 writes are harmless; anything else must have been pending
            if ((gnt_addr != '0) && !busy_q[gnt_addr]) begin
                wb_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q       <= '0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign wb0_ready       = gnt0;
    assign wb1_ready       = gnt1;
    assign regs_write_en   = we_q;
    assign regs_write_addr = waddr_q;
    assign regs_write_data = wdata_q;
    assign busy            = busy_q;
    assign wb_err          = wb_err_q;

endmodule

// File: doc/regs_scoreboard.md
# regs_scoreboard

Register-file hazard scoreboard and write-back port arbiter for the core. Decode presents its source and destination register addresses each cycle, and the block stalls issue while any of those registers has a write outstanding. Two write-back requesters, wb0 (ALU) and wb1 (LSU), share the single register-file write port under round-robin arbitration. The block drives `regs_write_en`/`regs_write_addr`/`regs_write_data` into the register file from registered state.

## Interface
- `REG_NUM`, 32: number of architectural registers; x0 is hardwired zero.
- `REG_AW`, 5: register address width.
- `XLEN`, 32: data width.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low: all state clears immediately while `rst`=0.
- `issue_valid`  in  1  decode holds an instruction.
- `issue_rs1`, `issue_rs2`  in  REG_AW  source addresses.
- `issue_rs1_en`, `issue_rs2_en`  in  1  the source is actually read.
- `issue_rd`  in  REG_AW  destination address.
- `issue_rd_en`  in  1  the instruction writes `rd`.
- `issue_ready`  out  1  no hazard; the instruction issues when `issue_valid & issue_ready`.
- `wb0_valid`, `wb1_valid`  in  1  write-back request.
- `wb0_addr`, `wb1_addr`  in  REG_AW  destination address.
- `wb0_data`, `wb1_data`  in  XLEN  write data.
- `wb0_ready`, `wb1_ready`  out  1  grant; the transfer completes when valid & ready.
- `regs_write_en`  out  1  register-file write strobe (registered).
- `regs_write_addr`  out  REG_AW  register-file write address (registered).
- `regs_write_data`  out  XLEN  register-file write data (registered).
- `busy`  out  REG_NUM  scoreboard vector (debug/observation).
- `wb_err`  out  1  sticky: a write-back targeted a non-busy register.

## Operation
- State elements:
  - `busy[REG_NUM-1:0]`
  - `last_grant` (0 = wb0, 1 = wb1)
  - output registers `regs_write_*`
  - `wb_err`
- Reset values:
  - `busy` = 0
  - `last_grant` = 1, so wb0 wins the first contention
  - `regs_write_en` = 0, `regs_write_addr` = 0, `regs_write_data` = 0
  - `wb_err` = 0
- Hazard rule: `issue_ready` = !(rs1_en & busy[rs1]) & !(rs2_en & busy[rs2]) & !(rd_en & busy[rd]).
  - The first two terms cover RAW hazards; the third covers WAW.
  - `busy[0]` is constant 0, so x0 never stalls.
- Issue: on `issue_valid & issue_ready & issue_rd_en & rd!=0`, set `busy[rd]` at the clock edge.
- Arbitration (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester ≠ `last_grant`.
  - `last_grant` updates to the granted index on every grant.
  - At most one ready is high per cycle.
- Grant edge: load `regs_write_en`=1 and `regs_write_addr`/`regs_write_data` from the granted requester. With no grant, `regs_write_en`=0 next cycle; addr and data hold their values.
- Retire: while `regs_write_en`=1, clear `busy[regs_write_addr]` at the clock edge. This is the same edge at which the register file commits the write.
- Write-back to x0: the write is still forwarded to the register file, which ignores it; no error is flagged.
- Write-back with addr≠0 whose `busy` bit is 0 at the grant cycle: the write still proceeds and `wb_err` sets. `wb_err` clears only on reset.
- Simultaneous issue-set and retire-clear on the same register cannot occur, because the WAW term stalls the issue. Issue-set on reg A together with retire-clear on reg B applies both.
- Reset mid-operation: all pending `busy` bits are lost and any in-flight output write is dropped. Upstream units are flushed by the same reset.

## Timing
- `issue_ready`, `wb0_ready`, `wb1_ready` are combinational from current state and inputs; there is no path from ready back to valid.
- Write-back latency, for a grant in cycle N:
  - `regs_write_en`=1 in cycle N+1.
  - `busy` bit clears at the end of N+1.
  - A dependent instruction sees `issue_ready`=1 in N+2.
- The write port sustains one write per cycle. Under continuous contention grants alternate wb0, wb1, wb0, …
- An issue in cycle N with `rd`=k makes `busy[k]`=1 from N+1. The earliest matching write-back grant is in N+1.

## Test plan
- Reset: hold `rst`=0 with random inputs. Require `busy`=0, `regs_write_en`=0, `wb_err`=0, and `wb0_ready`=1 when only `wb0_valid`=1.
- RAW stall:
  - Issue rd=5 in cycle 0.
  - From cycle 1, present rs1=5 with `rs1_en`=1: `issue_ready`=0.
  - wb0 addr=5, data=0xDEADBEEF, granted in cycle 3.
  - `regs_write_en`=1 with addr 5 and data 0xDEADBEEF in cycle 4; `issue_ready`=1 in cycle 5.
- WAW and x0:
  - With `busy[7]`=1, rd=7 with `rd_en`=1: `issue_ready`=0.
  - rd=0 and rs1=0 with both enables set: `issue_ready`=1, and `busy` stays 0.
- Round-robin: wb0 and wb1 valid for 4 cycles on rd 1, 2, 3, 4 (all busy). Grants go wb0, wb1, wb0, wb1, and `regs_write_addr` sequences match, one per cycle.
- Error flag: wb1 write-back to addr 9 with `busy[9]`=0. The write appears on `regs_write_*` next cycle, `wb_err`=1, and it stays 1 until reset.
- Reset mid-op: assert `rst`=0 while `busy`=0x0000_00A0 and `regs_write_en`=1. Require all outputs to clear immediately, without waiting for a clock edge.
